// File: rtl/ip_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ip_bus_arbiter
//   Sequences internal bus accesses coming from the MSX cartridge bus
//   front-end. A rising edge on any of the four level strobes starts one
//   transaction. The access is decoded to a target (0 = memory, 1..3 = I/O
//   windows), a request/ack handshake runs with that target under a timeout,
//   and read data is returned to the front-end with a one-cycle ready pulse.
//
//   Optional build macro: BUS_ARBITER_STATS_EN adds the saturating
//   timeout_count output.
//
// Ports
//   clk, reset           system clock, asynchronous active-high reset
//   bus_address          access address from the front-end
//   bus_write_data       write data from the front-end
//   bus_io_read/write    I/O strobe levels
//   bus_memory_read/write memory strobe levels
//   bus_read_ready       one-cycle pulse, bus_read_data valid
//   bus_read_data        read data (held until the next read completes)
//   tgt_req              one-hot target request
//   tgt_write, tgt_io    access kind, valid while a request is active
//   tgt_address, tgt_wdata latched address / write data
//   tgt_ack              per-target acknowledge
//   tgt_rdata            target n read data on bits [8n+7:8n]
//   timeout_error        sticky timeout flag
//   timeout_count        (BUS_ARBITER_STATS_EN) saturating timeout counter
// ---------------------------------------------------------------------------
module ip_bus_arbiter #(
  parameter logic [7:0]  IO_BASE1 = 8'h00,
  parameter logic [7:0]  IO_BASE2 = 8'h10,
  parameter logic [7:0]  IO_BASE3 = 8'h20,
  parameter logic [7:0]  IO_MASK  = 8'hF0,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_address,
  input  logic [7:0]  bus_write_data,
  input  logic        bus_io_read,
  input  logic        bus_io_write,
  input  logic        bus_memory_read,
  input  logic        bus_memory_write,
  output logic        bus_read_ready,
  output logic [7:0]  bus_read_data,
  output logic [3:0]  tgt_req,
  output logic        tgt_write,
  output logic        tgt_io,
  output logic [15:0] tgt_address,
  output logic [7:0]  tgt_wdata,
  input  logic [3:0]  tgt_ack,
  input  logic [31:0] tgt_rdata,
  output logic        timeout_error
`ifdef BUS_ARBITER_STATS_EN
  ,
  output logic [7:0]  timeout_count
`endif
);

  // Last counter value of the request window; at this count an absent ack
  // turns into a timeout.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // Strobe indices, in descending priority order.
  localparam logic [1:0] SRC_MEM_RD = 2'd0;
  localparam logic [1:0] SRC_MEM_WR = 2'd1;
  localparam logic [1:0] SRC_IO_RD  = 2'd2;
  localparam logic [1:0] SRC_IO_WR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_END = 2'd2
  } state_t;

  // Map an access to its one-hot target; all zero means no I/O window hit.
  function automatic logic [3:0] decode_target(input logic is_io, input logic [7:0] port);
    logic [7:0] masked;
    masked = port & IO_MASK;
    if (!is_io) begin
      decode_target = 4'b0001;
    end else if (masked == IO_BASE1) begin
      decode_target = 4'b0010;
    end else if (masked == IO_BASE2) begin
      decode_target = 4'b0100;
    end else if (masked == IO_BASE3) begin
      decode_target = 4'b1000;
    end else begin
      decode_target = 4'b0000;
    end
  endfunction

  // Binary index of a one-hot target vector.
  function automatic logic [1:0] onehot_index(input logic [3:0] oh);
    case (oh)
      4'b0010: onehot_index = 2'd1;
      4'b0100: onehot_index = 2'd2;
      4'b1000: onehot_index = 2'd3;
      default: onehot_index = 2'd0;
    endcase
  endfunction

  state_t      state_r, state_nxt_s;
  logic [3:0]  level_s;
  logic [3:0]  level_prev_r;
  logic [3:0]  rise_s;
  logic        start_s;
  logic [1:0]  src_s;
  logic [1:0]  src_r;
  logic        start_write_s;
  logic        start_io_s;
  logic [3:0]  decode_s;
  logic [1:0]  tgt_idx_r;
  logic [7:0]  cnt_r;
  logic        ack_ok_s;
  logic        tmo_s;
  logic        src_level_s;
  logic [7:0]  rdata_sel_s;

  assign level_s = {bus_io_write, bus_io_read, bus_memory_write, bus_memory_read};
  assign rise_s  = level_s & ~level_prev_r;

  // Pick the highest-priority rising strobe as the transaction source
  always_comb begin
    start_s = 1'b0;
    src_s   = SRC_MEM_RD;
    if (rise_s[0]) begin
      start_s = 1'b1;
      src_s   = SRC_MEM_RD;
    end else if (rise_s[1]) begin
      start_s = 1'b1;
      src_s   = SRC_MEM_WR;
    end else if (rise_s[2]) begin
      start_s = 1'b1;
      src_s   = SRC_IO_RD;
    end else if (rise_s[3]) begin
      start_s = 1'b1;
      src_s   = SRC_IO_WR;
    end else begin
      start_s = 1'b0;
      src_s   = SRC_MEM_RD;
    end
  end

  assign start_write_s = (src_s == SRC_MEM_WR) || (src_s == SRC_IO_WR);
  assign start_io_s    = (src_s == SRC_IO_RD)  || (src_s == SRC_IO_WR);
  assign decode_s      = decode_target(start_io_s, bus_address[7:0]);

  // Only the bit of the currently requested target counts as an ack.
  assign ack_ok_s    = (state_r == ST_REQ) && ((tgt_ack & tgt_req) != 4'b0000);
  // An ack in the final window cycle wins over the timeout.
  assign tmo_s       = (state_r == ST_REQ) && (cnt_r == CNT_LAST) && !ack_ok_s;
  assign src_level_s = level_s[src_r];
  assign rdata_sel_s = tgt_rdata[{tgt_idx_r, 3'b000} +: 8];

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          if (decode_s != 4'b0000) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_WAIT_END;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_ok_s || tmo_s) begin
          state_nxt_s = ST_WAIT_END;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT_END: begin
        // One transaction per strobe assertion: hold until the source drops.
        if (!src_level_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_END;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Strobe history, transaction latches, request window and return path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_prev_r   <= 4'b0000;
      src_r          <= SRC_MEM_RD;
      tgt_idx_r      <= 2'd0;
      cnt_r          <= 8'd0;
      tgt_req        <= 4'b0000;
      tgt_write      <= 1'b0;
      tgt_io         <= 1'b0;
      tgt_address    <= 16'h0000;
      tgt_wdata      <= 8'h00;
      bus_read_ready <= 1'b0;
      bus_read_data  <= 8'h00;
      timeout_error  <= 1'b0;
    end else begin
      level_prev_r   <= level_s;
      bus_read_ready <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            src_r       <= src_s;
            tgt_address <= bus_address;
            tgt_wdata   <= bus_write_data;
            tgt_write   <= start_write_s;
            tgt_io      <= start_io_s;
            tgt_req     <= decode_s;
            tgt_idx_r   <= onehot_index(decode_s);
            cnt_r       <= 8'd0;
          end
        end
        ST_REQ: begin
          if (ack_ok_s) begin
            tgt_req <= 4'b0000;
            if (!tgt_write) begin
              bus_read_data  <= rdata_sel_s;
              bus_read_ready <= 1'b1;
            end
          end else if (tmo_s) begin
            tgt_req       <= 4'b0000;
            timeout_error <= 1'b1;
            if (!tgt_write) begin
              bus_read_data  <= 8'hFF;
              bus_read_ready <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

`ifdef BUS_ARBITER_STATS_EN
  // Saturating count of request timeouts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_count <= 8'h00;
    end else if (tmo_s && (timeout_count != 8'hFF)) begin
      timeout_count <= timeout_count + 8'h01;
    end else begin
      timeout_count <= timeout_count;
    end
  end
`endif

endmodule
